hit_sequencer: RTL and testbench
================================

// Module: hit_sequencer
// PURPOSE
//  Arbitrates hit requests from N_REQ attack sources that target one player. Sequences the player's
//  physics_coprocessor attack and freeze inputs: APPLY, then HITSTUN, then optional INVULN.
//  Owns the player's damage register, which drives physics damage_in for knockback scaling.
//  One instance per player, between the attack logic and physics_coprocessor.
// PARAMETERS
//  N_REQ          2    number of hit requesters (1..4)
//  APPLY_CYCLES   64   cycles attack_out is held high per accepted hit (>=1)
//  HITSTUN_CYCLES 2048 cycles freeze_out is held high after APPLY (>=1)
//  INVULN_CYCLES  4096 cycles of invulnerability after HITSTUN (>=1; only with HIT_INVULN_EN)
//  DMG_MAX        999  damage saturation value
// PORTS
//  clock         in  1        system clock; all logic on posedge
//  reset_n       in  1        synchronous, active-low reset
//  req           in  N_REQ    hit request per source; held high until its ack pulse
//  req_kb        in  32*N_REQ knockback per source {x[31:16], y[15:0]}, signed; valid while req high
//  req_mv        in  32*N_REQ attack movement per source {x, y}, signed
//  req_dmg       in  8*N_REQ  damage per source, unsigned
//  ack           out N_REQ    one-cycle pulse per source when its request is consumed
//  hit_landed    out 1        valid with ack: 1 = hit applied, 0 = dropped (invulnerable)
//  pause_in      in  1        game pause: stalls all counters and forces freeze_out
//  damage_clr    in  1        respawn: zero the damage register
//  attack_out    out 1        to physics attack_in
//  knockback_out out 32       to physics knockback_in; latched at grant
//  movement_out  out 32       to physics movement_in; latched at grant
//  freeze_out    out 1        to physics freeze_in
//  damage_out    out 16       to physics damage_in; unsigned, 0..DMG_MAX
// BEHAVIOUR
//  Reset (reset_n==0 at posedge), including mid-operation:
//   - state IDLE, all counters 0, RR pointer 0.
//   - ack, hit_landed, attack_out, freeze_out = 0; knockback_out, movement_out, damage_out = 0.
//  FSM states: IDLE, APPLY, HITSTUN, INVULN. All outputs registered.
//   - IDLE: if any req, the round-robin winner g is granted at edge t.
//     - At t+1: ack[g]=1, hit_landed=1, attack_out=1, state APPLY.
//     - knockback_out/movement_out = req_kb[g]/req_mv[g], sampled at t.
//     - damage_out = min(damage_out + req_dmg[g], DMG_MAX).
//   - APPLY: attack_out high for exactly APPLY_CYCLES cycles. Then HITSTUN with attack_out=0.
//     - kb/mv stay stable throughout APPLY.
//   - HITSTUN: freeze_out high for exactly HITSTUN_CYCLES cycles. Then INVULN, or IDLE without macro.
//   - INVULN: lasts INVULN_CYCLES cycles, then IDLE.
//  Requests seen in any non-IDLE state:
//   - INVULN: the RR winner gets ack=1, hit_landed=0 (dropped, no damage). At most one drop per cycle.
//   - APPLY/HITSTUN: requests are held, not acked; served on return to IDLE.
//  Round-robin:
//   - Search starts at pointer p. After a landed grant to g, p = (g+1) mod N_REQ.
//   - Drops do not move p.
//   - Simultaneous requests with p=0: source 0 wins, then source 1 on the next IDLE.
//  A source's req may rise again one cycle after its ack; its next IDLE grant is then legal.
//  pause_in=1:
//   - Freezes state and counters; no grants and no drops.
//   - freeze_out=1; attack_out holds its current value.
//   - On release, sequencing continues from the same count.
//  damage_clr:
//   - damage_out=0 next cycle. Takes priority over a same-cycle grant's add.
//   - The grant itself still proceeds.
//  Damage add is 17-bit, saturating to DMG_MAX; it never wraps.
//  Counter width is $clog2(max cycles)+1. No counter wrap-around is permitted.
// CONFIGURATION
//  HIT_INVULN_EN defined:
//   - INVULN state exists; requests during it are dropped as above.
//  HIT_INVULN_EN undefined:
//   - HITSTUN goes directly to IDLE; hit_landed is always 1 when ack pulses.
//   - INVULN_CYCLES is ignored.
// STRUCTURE
//  Package smash_phys_pkg: state encoding (IDLE=0, APPLY=1, HITSTUN=2, INVULN=3), DMG_MAX default,
//   kb/mv field offsets (X_MSB=31, Y_MSB=15).
//  Sub-module hit_rr_arbiter (N_REQ): inputs req and ptr; outputs one-hot grant and valid.
//   Combinational, reused by the attack coprocessor.
//  FSM, counters, damage register and output latches live in hit_sequencer.
// TESTING
//  1. Reset mid-HITSTUN -> next cycle all outputs 0, state IDLE, damage_out 0.
//  2. req[0], kb=0x0010_FFF0, dmg=12; APPLY=4, HITSTUN=8:
//     - ack[0] and hit_landed at t+1; attack_out high 4 cycles; then freeze_out high 8 cycles.
//     - knockback_out=0x0010FFF0 throughout; damage_out=12.
//  3. req=2'b11 in IDLE, p=0 -> src0 landed first; src1 landed on the next IDLE after HITSTUN.
//  4. HIT_INVULN_EN, req[1] during INVULN -> ack[1]=1, hit_landed=0, damage unchanged, p unchanged.
//     Same request after INVULN ends -> landed.
//  5. damage_out=990, dmg=20 -> 999. Same-cycle damage_clr and grant -> damage 0, attack_out still asserted.
//  6. pause_in for 10 cycles mid-APPLY:
//     - freeze_out=1 throughout; attack_out still high.
//     - APPLY total duration extended by exactly 10 cycles.

Source files
------------

// File: rtl/smash_phys_pkg.sv
// Shared types and constants for the player physics front end.
// State encoding, damage ceiling and kb/mv vector field layout.
package smash_phys_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    HITSTUN = 2'd2,
    INVULN  = 2'd3
  } hit_state_t;

  localparam int DMG_MAX_DEF = 999;

  localparam int X_MSB  = 31;
  localparam int Y_MSB  = 15;
  localparam int AXIS_W = X_MSB - Y_MSB;
  localparam int VEC_W  = 2 * AXIS_W;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hit_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr.
// Also used by the attack coprocessor.
module hit_rr_arbiter
  import smash_phys_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [ptr_w(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]        grant,
  output logic                    valid
);

  always_comb begin
    int t;
    t     = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      t = int'(ptr) + i;
      if (t >= N_REQ) t = t - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid && req[j] && (j == t)) begin
          grant[j] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hit_sequencer.sv
// Per-player hit sequencer: APPLY -> HITSTUN (-> INVULN) plus damage.
// Optional invulnerability window: define HIT_INVULN_EN.
module hit_sequencer
  import smash_phys_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int APPLY_CYCLES   = 64,
  parameter int HITSTUN_CYCLES = 2048,
  parameter int INVULN_CYCLES  = 4096,
  parameter int DMG_MAX        = DMG_MAX_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [32*N_REQ-1:0]    req_kb,
  input  logic [32*N_REQ-1:0]    req_mv,
  input  logic [8*N_REQ-1:0]     req_dmg,
  output logic [N_REQ-1:0]       ack,
  output logic                   hit_landed,
  input  logic                   pause_in,
  input  logic                   damage_clr,
  output logic                   attack_out,
  output logic [31:0]            knockback_out,
  output logic [31:0]            movement_out,
  output logic                   freeze_out,
  output logic [15:0]            damage_out
);

  localparam int PW = ptr_w(N_REQ);
  localparam int CW =
    $clog2(max3(APPLY_CYCLES, HITSTUN_CYCLES, INVULN_CYCLES)) + 1;
  localparam logic [CW-1:0] A_LAST = CW'(APPLY_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HITSTUN_CYCLES - 1);
`ifdef HIT_INVULN_EN
  localparam logic [CW-1:0] I_LAST = CW'(INVULN_CYCLES - 1);
`endif
  localparam logic [16:0] DMAX17 = 17'(DMG_MAX);

  hit_state_t        state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [PW-1:0]     ptr, ptr_d, nptr;
  logic [N_REQ-1:0]  grant, ack_d;
  logic              valid, landed_d;
  logic              attack_d, freeze_d;
  logic [31:0]       kb_sel, mv_sel, kb_d, mv_d;
  logic [7:0]        dmg_sel;
  logic [16:0]       sum;
  logic [15:0]       dmg_sat, dmg_d;

  // A source still sees its ack this cycle; keep it out of arbitration.
  hit_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req & ~ack),
    .ptr   (ptr),
    .grant (grant),
    .valid (valid)
  );

  always_comb begin
    kb_sel  = '0;
    mv_sel  = '0;
    dmg_sel = '0;
    nptr    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        kb_sel  = req_kb[i*VEC_W +: VEC_W];
        mv_sel  = req_mv[i*VEC_W +: VEC_W];
        dmg_sel = req_dmg[i*8 +: 8];
        nptr    = (i == N_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
    sum     = {1'b0, damage_out} + {9'b0, dmg_sel};
    dmg_sat = (sum > DMAX17) ? DMAX17[15:0] : sum[15:0];
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ptr_d    = ptr;
    ack_d    = '0;
    landed_d = 1'b0;
    kb_d     = knockback_out;
    mv_d     = movement_out;
    dmg_d    = damage_out;
    if (!pause_in) begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            state_d  = APPLY;
            cnt_d    = '0;
            ptr_d    = nptr;
            ack_d    = grant;
            landed_d = 1'b1;
            kb_d     = kb_sel;
            mv_d     = mv_sel;
            dmg_d    = dmg_sat;
          end
        end
        APPLY: begin
          if (cnt == A_LAST) begin
            state_d = HITSTUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        HITSTUN: begin
          if (cnt == H_LAST) begin
            cnt_d = '0;
`ifdef HIT_INVULN_EN
            state_d = INVULN;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        INVULN: begin
`ifdef HIT_INVULN_EN
          if (valid) ack_d = grant;
          if (cnt == I_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
`else
          state_d = IDLE;
          cnt_d   = '0;
`endif
        end
      endcase
    end
    if (damage_clr) dmg_d = '0;
    attack_d = (state_d == APPLY);
    freeze_d = pause_in | (state_d == HITSTUN);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= '0;
      ack           <= '0;
      hit_landed    <= 1'b0;
      attack_out    <= 1'b0;
      freeze_out    <= 1'b0;
      knockback_out <= '0;
      movement_out  <= '0;
      damage_out    <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ptr           <= ptr_d;
      ack           <= ack_d;
      hit_landed    <= landed_d;
      attack_out    <= attack_d;
      freeze_out    <= freeze_d;
      knockback_out <= kb_d;
      movement_out  <= mv_d;
      damage_out    <= dmg_d;
    end
  end

endmodule

// File: tb/tb_hit_sequencer.sv
// Bench for hit_sequencer: vector table plus hand-written corner sequences.
// Ack-time results are checked against a queue of expected records.
module tb_hit_sequencer;

  localparam int N  = 2;
  localparam int AP = 4;
  localparam int HS = 8;
  localparam int IV = 6;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [63:0] req_kb = '0;
  logic [63:0] req_mv = '0;
  logic [15:0] req_dmg = '0;
  logic        pause_in = 1'b0;
  logic        damage_clr = 1'b0;
  logic [1:0]  ack;
  logic        hit_landed;
  logic        attack_out;
  logic [31:0] knockback_out;
  logic [31:0] movement_out;
  logic        freeze_out;
  logic [15:0] damage_out;

  hit_sequencer #(
    .N_REQ(N), .APPLY_CYCLES(AP), .HITSTUN_CYCLES(HS),
    .INVULN_CYCLES(IV), .DMG_MAX(999)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .req_kb(req_kb), .req_mv(req_mv), .req_dmg(req_dmg),
    .ack(ack), .hit_landed(hit_landed),
    .pause_in(pause_in), .damage_clr(damage_clr),
    .attack_out(attack_out), .knockback_out(knockback_out),
    .movement_out(movement_out), .freeze_out(freeze_out),
    .damage_out(damage_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ack;
    logic        landed;
    logic [31:0] kb;
    logic [31:0] mv;
    logic [15:0] dmg;
  } exp_t;

  typedef struct {
    int          src;
    logic [31:0] kb;
    logic [31:0] mv;
    logic [7:0]  dmg;
    logic [15:0] exp_dmg;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && ack != 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_ack: got ack=%b expected none", ack);
      end else begin
        e = sb.pop_front();
        chk("sb_ack", 32'(ack), 32'(e.ack));
        chk("sb_landed", 32'(hit_landed), 32'(e.landed));
        chk("sb_kb", knockback_out, e.kb);
        chk("sb_mv", movement_out, e.mv);
        chk("sb_dmg", 32'(damage_out), 32'(e.dmg));
      end
    end
  end

  task automatic push(input logic [1:0] a, input logic l,
                      input logic [31:0] kb, input logic [31:0] mv,
                      input logic [15:0] d);
    exp_t x;
    x.ack = a; x.landed = l; x.kb = kb; x.mv = mv; x.dmg = d;
    sb.push_back(x);
  endtask

  task automatic set_src(input int s, input logic [31:0] kb,
                         input logic [31:0] mv, input logic [7:0] d);
    req_kb[s*32 +: 32] = kb;
    req_mv[s*32 +: 32] = mv;
    req_dmg[s*8 +: 8]  = d;
    req[s]             = 1'b1;
  endtask

  task automatic wait_ack(input int s, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ack[s] && n < 40);
    if (!ack[s]) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: src %0d got no ack, required within 40", s);
    end
  endtask

  task automatic run_pulse(input logic [31:0] kbx, input logic [31:0] mvx,
                           input bit settle,
                           output int a, output int f, output int bad);
    a = 0; f = 0; bad = 0;
    while (attack_out && a < 200) begin
      if (knockback_out !== kbx || movement_out !== mvx) bad++;
      a++;
      @(negedge clock);
    end
    while (freeze_out && f < 400) begin
      f++;
      @(negedge clock);
    end
`ifdef HIT_INVULN_EN
    if (settle) repeat (IV + 2) @(negedge clock);
`else
    if (settle) @(negedge clock);
`endif
  endtask

  initial begin
    int n, a, f, bad, pa;
    bit pok;
    #200000;
    $display("FAIL watchdog: got no finish, required finish by 200000");
    $fatal(1);
  end

  initial begin
    int n, a, f, bad, pa;
    bit pok;
    vecs[0] = '{0, 32'h7FFF_8000, 32'h0001_0002, 8'd200, 16'd212};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'h8000_7FFF, 8'd255, 16'd467};
    vecs[2] = '{0, 32'h1234_5678, 32'hDEAD_BEEF, 8'd255, 16'd722};
    vecs[3] = '{1, 32'h0000_0001, 32'hFFFE_0003, 8'd255, 16'd977};
    vecs[4] = '{1, 32'hCAFE_0000, 32'h0000_0000, 8'd13,  16'd990};
    vecs[5] = '{0, 32'h0BAD_F00D, 32'h0101_0101, 8'd20,  16'd999};
    vecs[6] = '{1, 32'h5555_AAAA, 32'h0F0F_F0F0, 8'd255, 16'd999};

    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_attack", 32'(attack_out), 32'd0);
    chk("rst_freeze", 32'(freeze_out), 32'd0);
    chk("rst_kb", knockback_out, 32'd0);
    chk("rst_dmg", 32'(damage_out), 32'd0);
    reset_n = 1'b1;

    // single landed hit with full APPLY/HITSTUN timing
    push(2'b01, 1'b1, 32'h0010_FFF0, 32'h0003_FFFD, 16'd12);
    set_src(0, 32'h0010_FFF0, 32'h0003_FFFD, 8'd12);
    wait_ack(0, n);
    chk("hit_latency", n, 1);
    req[0] = 1'b0;
    run_pulse(32'h0010_FFF0, 32'h0003_FFFD, 1'b1, a, f, bad);
    chk("hit_apply_len", a, AP);
    chk("hit_stun_len", f, HS);
    chk("hit_kb_stable", bad, 0);
    chk("hit_dmg", 32'(damage_out), 32'd12);

    // reset in the middle of HITSTUN
    push(2'b01, 1'b1, 32'h0000_0100, 32'h0000_0200, 16'd42);
    set_src(0, 32'h0000_0100, 32'h0000_0200, 8'd30);
    wait_ack(0, n);
    req[0] = 1'b0;
    n = 0;
    while (attack_out && n < 200) begin
      n++;
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    chk("mid_freeze", 32'(freeze_out), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mrst_ack", 32'(ack), 32'd0);
    chk("mrst_landed", 32'(hit_landed), 32'd0);
    chk("mrst_attack", 32'(attack_out), 32'd0);
    chk("mrst_freeze", 32'(freeze_out), 32'd0);
    chk("mrst_kb", knockback_out, 32'd0);
    chk("mrst_mv", movement_out, 32'd0);
    chk("mrst_dmg", 32'(damage_out), 32'd0);
    reset_n = 1'b1;

    // simultaneous requests, pointer back at 0
    push(2'b01, 1'b1, 32'hAAAA_0001, 32'h1111_0001, 16'd5);
    set_src(0, 32'hAAAA_0001, 32'h1111_0001, 8'd5);
    set_src(1, 32'hBBBB_0002, 32'h2222_0002, 8'd7);
    wait_ack(0, n);
    req[0] = 1'b0;
    run_pulse(32'hAAAA_0001, 32'h1111_0001, 1'b0, a, f, bad);
    chk("rr0_apply_len", a, AP);
    chk("rr0_stun_len", f, HS);
`ifdef HIT_INVULN_EN
    push(2'b10, 1'b0, 32'hAAAA_0001, 32'h1111_0001, 16'd5);
    wait_ack(1, n);
    req[1] = 1'b0;
    repeat (IV + 2) @(negedge clock);
    req[1] = 1'b1;
`endif
    push(2'b10, 1'b1, 32'hBBBB_0002, 32'h2222_0002, 16'd12);
    wait_ack(1, n);
    chk("rr1_next_idle", n, 1);
    req[1] = 1'b0;
    run_pulse(32'hBBBB_0002, 32'h2222_0002, 1'b1, a, f, bad);
    chk("rr1_apply_len", a, AP);

    for (int i = 0; i < 7; i++) begin
      push(2'b01 << vecs[i].src, 1'b1, vecs[i].kb, vecs[i].mv,
           vecs[i].exp_dmg);
      set_src(vecs[i].src, vecs[i].kb, vecs[i].mv, vecs[i].dmg);
      wait_ack(vecs[i].src, n);
      req[vecs[i].src] = 1'b0;
      run_pulse(vecs[i].kb, vecs[i].mv, 1'b1, a, f, bad);
      chk("vec_apply_len", a, AP);
      chk("vec_stun_len", f, HS);
      chk("vec_kb_stable", bad, 0);
    end

    // damage_clr together with a grant
    push(2'b01, 1'b1, 32'h0042_0042, 32'h0007_0007, 16'd0);
    damage_clr = 1'b1;
    set_src(0, 32'h0042_0042, 32'h0007_0007, 8'd50);
    wait_ack(0, n);
    damage_clr = 1'b0;
    req[0] = 1'b0;
    chk("clr_attack", 32'(attack_out), 32'd1);
    run_pulse(32'h0042_0042, 32'h0007_0007, 1'b1, a, f, bad);
    chk("clr_dmg_hold", 32'(damage_out), 32'd0);

    // pause for 10 cycles inside APPLY
    push(2'b10, 1'b1, 32'h0009_0009, 32'h0001_FFFF, 16'd9);
    set_src(1, 32'h0009_0009, 32'h0001_FFFF, 8'd9);
    wait_ack(1, n);
    req[1] = 1'b0;
    pa = int'(attack_out);
    @(negedge clock);
    pa += int'(attack_out);
    pause_in = 1'b1;
    pok = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!freeze_out || !attack_out) pok = 1'b0;
      pa += int'(attack_out);
    end
    pause_in = 1'b0;
    @(negedge clock);
    run_pulse(32'h0009_0009, 32'h0001_FFFF, 1'b1, a, f, bad);
    pa += a;
    chk("pause_flags", 32'(pok), 32'd1);
    chk("pause_apply_len", pa, AP + 10);
    chk("pause_stun_len", f, HS);

`ifdef HIT_INVULN_EN
    // drop during INVULN, pointer must not move
    push(2'b01, 1'b1, 32'h0003_0003, 32'h0000_0003, 16'd12);
    set_src(0, 32'h0003_0003, 32'h0000_0003, 8'd3);
    wait_ack(0, n);
    req[0] = 1'b0;
    run_pulse(32'h0003_0003, 32'h0000_0003, 1'b0, a, f, bad);
    push(2'b10, 1'b0, 32'h0003_0003, 32'h0000_0003, 16'd12);
    set_src(1, 32'h0064_0064, 32'h0000_0064, 8'd100);
    wait_ack(1, n);
    chk("inv_drop_latency", n, 1);
    req[1] = 1'b0;
    repeat (IV + 2) @(negedge clock);
    push(2'b10, 1'b1, 32'h0064_0064, 32'h0000_0064, 16'd112);
    push(2'b01, 1'b0, 32'h0064_0064, 32'h0000_0064, 16'd112);
    set_src(1, 32'h0064_0064, 32'h0000_0064, 8'd100);
    set_src(0, 32'h0003_0003, 32'h0000_0003, 8'd3);
    wait_ack(1, n);
    req[1] = 1'b0;
    run_pulse(32'h0064_0064, 32'h0000_0064, 1'b0, a, f, bad);
    wait_ack(0, n);
    req[0] = 1'b0;
    repeat (IV + 2) @(negedge clock);
`endif

    repeat (5) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
